sd_spi_cmd_controller: RTL and testbench

SD-card SPI-mode command controller for the card-emulation side of the design. It consumes the parsed command frames produced by the SPI receiver (6-bit index plus 32-bit argument) and runs the card initialisation state machine (CMD0 / CMD8 / CMD55+ACMD41 / CMD58). It schedules the R1/R3/R7 response bytes onto the transmit byte slot after the configured NCR gap. Accepted CMD17 reads are handed off to the data path.

---
 rtl/sd_spi_cmd_controller_if.sv | 28 ++
 rtl/sd_spi_cmd_controller.sv | 161 ++++++++++++++++
 tb/tb_sd_spi_cmd_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_cmd_controller_if.sv
// Command-frame and transmit-slot signals between the SPI front end and the
// SD-card command controller.
interface sd_spi_cmd_controller_if;
   logic        io_CommandValid;
   logic [5:0]  io_Command;
   logic [31:0] io_CommandArgument;
   logic        io_ByteTick;
   logic        io_ChipSelect;
   logic [7:0]  io_TxData;
   logic [1:0]  io_CardState;
   logic        io_Busy;
   logic        io_Dropped;
   logic [7:0]  io_IllegalCount;
   logic        io_DataRequest;
   logic [31:0] io_DataAddress;

   modport master (
      output io_CommandValid, io_Command, io_CommandArgument, io_ByteTick, io_ChipSelect,
      input  io_TxData, io_CardState, io_Busy, io_Dropped, io_IllegalCount,
             io_DataRequest, io_DataAddress
   );

   modport slave (
      input  io_CommandValid, io_Command, io_CommandArgument, io_ByteTick, io_ChipSelect,
      output io_TxData, io_CardState, io_Busy, io_Dropped, io_IllegalCount,
             io_DataRequest, io_DataAddress
   );
endinterface

// File: rtl/sd_spi_cmd_controller.sv
// SD-card SPI-mode command controller (card side): init state machine and
// R1/R3/R7 response scheduling onto the transmit byte slot.
module sd_spi_cmd_controller #(
   parameter int unsigned NCR          = 1,
   parameter int unsigned ACMD41_POLLS = 2,
   parameter logic [31:0] OCR          = 32'h00FF8000
) (
   input logic                    clock,
   input logic                    reset,
   sd_spi_cmd_controller_if.slave bus
);

   typedef enum logic [1:0] {WAIT_CMD0 = 2'd0, IDLE = 2'd1, READY = 2'd2} card_t;
   typedef enum logic [1:0] {R_WAIT = 2'd0, R_FILL = 2'd1, R_RESP = 2'd2} resp_t;

   card_t       card_state;
   resp_t       fsm;
   logic        app_flag;
   logic [7:0]  poll_cnt;
   logic [7:0]  illegal_cnt;
   logic [3:0]  fill_cnt;
   logic [2:0]  resp_left;
   logic [39:0] resp_sr;
   logic        read_pend;
   logic [7:0]  tx_data;
   logic        dropped;
   logic        data_request;
   logic [31:0] data_address;

   card_t       dec_card;
   logic [7:0]  dec_poll;
   logic        dec_illegal;
   logic        dec_read;
   logic [2:0]  dec_len;
   logic [31:0] dec_ext;
   logic [7:0]  dec_r1;
   logic        accept;

   assign accept = bus.io_CommandValid && !bus.io_ChipSelect && (fsm == R_WAIT) &&
                   ((card_state != WAIT_CMD0) || (bus.io_Command == 6'd0));

   // in_idle in R1 reflects the state after this command takes effect
   always_comb begin
      dec_card    = card_state;
      dec_poll    = poll_cnt;
      dec_illegal = 1'b0;
      dec_read    = 1'b0;
      dec_len     = 3'd1;
      dec_ext     = '1;
      case (bus.io_Command)
         6'd0: begin
            dec_card = IDLE;
            dec_poll = '0;
         end
         6'd8: begin
            dec_len = 3'd5;
            dec_ext = {20'h00000, bus.io_CommandArgument[11:0]};
         end
         6'd55: ;
         6'd41: begin
            if (!app_flag) begin
               dec_illegal = 1'b1;
            end else if (card_state != READY) begin
               dec_poll = poll_cnt + 8'd1;
               if (dec_poll == 8'(ACMD41_POLLS)) dec_card = READY;
            end
         end
         6'd58: begin
            dec_len = 3'd5;
            dec_ext = {card_state == READY, OCR[30:0]};
         end
         6'd17: begin
            if (card_state == READY) dec_read = 1'b1;
            else                     dec_illegal = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      dec_r1 = {5'b0, dec_illegal, 1'b0, dec_card == IDLE};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         card_state   <= WAIT_CMD0;
         fsm          <= R_WAIT;
         app_flag     <= 1'b0;
         poll_cnt     <= '0;
         illegal_cnt  <= '0;
         fill_cnt     <= '0;
         resp_left    <= '0;
         resp_sr      <= '1;
         read_pend    <= 1'b0;
         tx_data      <= 8'hFF;
         dropped      <= 1'b0;
         data_request <= 1'b0;
         data_address <= '0;
      end else begin
         dropped      <= 1'b0;
         data_request <= 1'b0;
         if (bus.io_ChipSelect) begin
            fsm       <= R_WAIT;
            tx_data   <= 8'hFF;
            app_flag  <= 1'b0;
            read_pend <= 1'b0;
         end else begin
            case (fsm)
               R_WAIT: begin
                  if (accept) begin
                     card_state <= dec_card;
                     poll_cnt   <= dec_poll;
                     app_flag   <= (bus.io_Command == 6'd55);
                     if (dec_illegal && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
                     if (dec_read) data_address <= bus.io_CommandArgument;
                     read_pend  <= dec_read;
                     resp_sr    <= {dec_r1, dec_ext};
                     resp_left  <= dec_len;
                     fill_cnt   <= 4'(NCR);
                     fsm        <= R_FILL;
                  end
               end
               R_FILL: begin
                  dropped <= bus.io_CommandValid;
                  if (bus.io_ByteTick) begin
                     if (fill_cnt == 4'd1) begin
                        tx_data <= resp_sr[39:32];
                        resp_sr <= {resp_sr[31:0], 8'hFF};
                        fsm     <= R_RESP;
                     end else begin
                        fill_cnt <= fill_cnt - 4'd1;
                     end
                  end
               end
               R_RESP: begin
                  dropped <= bus.io_CommandValid;
                  if (bus.io_ByteTick) begin
                     if (resp_left == 3'd1) begin
                        tx_data      <= 8'hFF;
                        data_request <= read_pend;
                        read_pend    <= 1'b0;
                        fsm          <= R_WAIT;
                     end else begin
                        tx_data   <= resp_sr[39:32];
                        resp_sr   <= {resp_sr[31:0], 8'hFF};
                        resp_left <= resp_left - 3'd1;
                     end
                  end
               end
               default: fsm <= R_WAIT;
            endcase
         end
      end
   end

   assign bus.io_TxData         = tx_data;
   assign bus.io_CardState      = card_state;
   assign bus.io_Busy           = (fsm != R_WAIT);
   assign bus.io_Dropped        = dropped;
   assign bus.io_IllegalCount   = illegal_cnt;
   assign bus.io_DataRequest    = data_request;
   assign bus.io_DataAddress    = data_address;

endmodule

// File: tb/tb_sd_spi_cmd_controller.sv
// Directed self-checking bench for sd_spi_cmd_controller (NCR=1, ACMD41_POLLS=2).
module tb_sd_spi_cmd_controller;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   dreq_seen = 0;
   logic [7:0] exp_b [5];

   sd_spi_cmd_controller_if bus();

   sd_spi_cmd_controller #(.NCR(1), .ACMD41_POLLS(2), .OCR(32'h00FF8000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(negedge clock) if (bus.io_DataRequest === 1'b1) dreq_seen++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [5:0] cmd, input logic [31:0] arg);
      bus.io_CommandValid    = 1'b1;
      bus.io_Command         = cmd;
      bus.io_CommandArgument = arg;
      @(negedge clock);
      bus.io_CommandValid    = 1'b0;
   endtask

   task automatic byte_tick();
      bus.io_ByteTick = 1'b1;
      @(negedge clock);
      bus.io_ByteTick = 1'b0;
   endtask

   // One fill slot (NCR=1), then n response bytes, then idle 0xFF with Busy low
   task automatic resp_check(input string tag, input int n);
      chk({tag, "_fill"}, 32'(bus.io_TxData), 32'hFF);
      byte_tick();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_b%0d", tag, i), 32'(bus.io_TxData), 32'(exp_b[i]));
         byte_tick();
      end
      chk({tag, "_end_tx"}, 32'(bus.io_TxData), 32'hFF);
      chk({tag, "_end_busy"}, 32'(bus.io_Busy), 32'h0);
   endtask

   initial begin
      bus.io_CommandValid    = 1'b0;
      bus.io_Command         = '0;
      bus.io_CommandArgument = '0;
      bus.io_ByteTick        = 1'b0;
      bus.io_ChipSelect      = 1'b0;
      repeat (3) @(negedge clock);

      chk("rst_tx", 32'(bus.io_TxData), 32'hFF);
      chk("rst_state", 32'(bus.io_CardState), 32'd0);
      chk("rst_busy", 32'(bus.io_Busy), 32'd0);
      chk("rst_dropped", 32'(bus.io_Dropped), 32'd0);
      chk("rst_illcnt", 32'(bus.io_IllegalCount), 32'd0);
      chk("rst_dreq", 32'(bus.io_DataRequest), 32'd0);
      chk("rst_addr", bus.io_DataAddress, 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // CMD8 before CMD0 is ignored outright
      send_cmd(6'd8, 32'h1AA);
      chk("pre_cmd8_busy", 32'(bus.io_Busy), 32'd0);
      chk("pre_cmd8_state", 32'(bus.io_CardState), 32'd0);
      chk("pre_cmd8_illcnt", 32'(bus.io_IllegalCount), 32'd0);

      send_cmd(6'd0, 32'h0);
      chk("cmd0_busy", 32'(bus.io_Busy), 32'd1);
      chk("cmd0_state", 32'(bus.io_CardState), 32'd1);
      exp_b[0] = 8'h01;
      resp_check("cmd0", 1);

      send_cmd(6'd8, 32'h000001AA);
      exp_b = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
      resp_check("cmd8", 5);

      send_cmd(6'd17, 32'h00001234);
      exp_b[0] = 8'h05;
      resp_check("cmd17_idle", 1);
      chk("cmd17_idle_illcnt", 32'(bus.io_IllegalCount), 32'd1);
      chk("cmd17_idle_dreq", 32'(dreq_seen), 32'd0);

      // Command arriving during FILL is dropped and the R7 continues untouched
      send_cmd(6'd8, 32'h000002BC);
      send_cmd(6'd0, 32'h0);
      chk("drop_pulse", 32'(bus.io_Dropped), 32'd1);
      exp_b = '{8'h01, 8'h00, 8'h00, 8'h02, 8'hBC};
      resp_check("drop_r7", 5);
      chk("drop_pulse_gone", 32'(bus.io_Dropped), 32'd0);

      // CS raised between R7 bytes 1 and 2
      send_cmd(6'd8, 32'h000001AA);
      byte_tick();
      chk("abort_b0", 32'(bus.io_TxData), 32'h01);
      byte_tick();
      chk("abort_b1", 32'(bus.io_TxData), 32'h00);
      bus.io_ChipSelect = 1'b1;
      @(negedge clock);
      bus.io_ChipSelect = 1'b0;
      chk("abort_tx", 32'(bus.io_TxData), 32'hFF);
      chk("abort_busy", 32'(bus.io_Busy), 32'd0);
      chk("abort_state", 32'(bus.io_CardState), 32'd1);

      send_cmd(6'd41, 32'h40000000);
      exp_b[0] = 8'h05;
      resp_check("cmd41_noapp", 1);
      chk("cmd41_noapp_illcnt", 32'(bus.io_IllegalCount), 32'd2);

      // App flag cleared by a CS-high cycle
      send_cmd(6'd55, 32'h0);
      exp_b[0] = 8'h01;
      resp_check("cmd55_cs", 1);
      bus.io_ChipSelect = 1'b1;
      @(negedge clock);
      bus.io_ChipSelect = 1'b0;
      send_cmd(6'd41, 32'h40000000);
      exp_b[0] = 8'h05;
      resp_check("cmd41_after_cs", 1);
      chk("cmd41_after_cs_illcnt", 32'(bus.io_IllegalCount), 32'd3);

      send_cmd(6'd55, 32'h0);
      exp_b[0] = 8'h01;
      resp_check("cmd55_a", 1);
      send_cmd(6'd41, 32'h40000000);
      resp_check("acmd41_a", 1);
      chk("acmd41_a_state", 32'(bus.io_CardState), 32'd1);
      send_cmd(6'd55, 32'h0);
      resp_check("cmd55_b", 1);
      send_cmd(6'd41, 32'h40000000);
      chk("acmd41_b_state", 32'(bus.io_CardState), 32'd2);
      exp_b[0] = 8'h00;
      resp_check("acmd41_b", 1);

      send_cmd(6'd58, 32'h0);
      exp_b = '{8'h00, 8'h80, 8'hFF, 8'h80, 8'h00};
      resp_check("cmd58", 5);

      send_cmd(6'd17, 32'h00001234);
      exp_b[0] = 8'h00;
      resp_check("cmd17_ready", 1);
      chk("cmd17_dreq_pulse", 32'(bus.io_DataRequest), 32'd1);
      chk("cmd17_addr", bus.io_DataAddress, 32'h00001234);
      chk("cmd17_illcnt", 32'(bus.io_IllegalCount), 32'd3);
      @(negedge clock);
      chk("cmd17_dreq_gone", 32'(bus.io_DataRequest), 32'd0);
      chk("cmd17_dreq_count", 32'(dreq_seen), 32'd1);

      send_cmd(6'd0, 32'h0);
      exp_b[0] = 8'h01;
      resp_check("cmd0_ready", 1);
      chk("cmd0_ready_state", 32'(bus.io_CardState), 32'd1);

      // Asynchronous reset in the middle of a response
      send_cmd(6'd8, 32'h000001AA);
      byte_tick();
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_tx", 32'(bus.io_TxData), 32'hFF);
      chk("mid_rst_busy", 32'(bus.io_Busy), 32'd0);
      chk("mid_rst_state", 32'(bus.io_CardState), 32'd0);
      chk("mid_rst_illcnt", 32'(bus.io_IllegalCount), 32'd0);
      chk("mid_rst_addr", bus.io_DataAddress, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
